// File: rtl/arb_pkg.sv
// Shared types, mode encodings and helpers for the N-way round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam logic MODE_RR = 1'b0;
  localparam logic MODE_FP = 1'b1;

  // Index of the set bit of a one-hot vector (zero for an all-zero vector).
  function automatic logic [3:0] onehot2idx(input logic [15:0] oh);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) r = r | 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_rr_n_if.sv
// Request/grant bundle between the bus masters and the arbiter.
interface arb_rr_n_if #(
  parameter int N = 4
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req;
  logic           mode;
  logic [N-1:0]   ack;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;

  modport master (
    output req,
    output mode,
    input  ack,
    input  grant_valid,
    input  grant_id
  );

  modport slave (
    input  req,
    input  mode,
    output ack,
    output grant_valid,
    output grant_id
  );

endinterface

// File: rtl/arb_pick.sv
// Combinational rotate-priority search: first unmasked request at or after start_idx,
// or the lowest unmasked request in fixed-priority mode.
module arb_pick
  import arb_pkg::*;
#(
  parameter int  N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] start_idx,
  input  logic           mode,
  output logic           found,
  output logic [IDW-1:0] idx
);

  localparam logic [IDW:0] N_W = (IDW + 1)'(N);

  logic [N-1:0]   cand;
  logic [N-1:0]   rot;
  logic [N-1:0]   rot_oh;
  logic [IDW-1:0] start_eff;
  logic [15:0]    rot_wide;
  logic [3:0]     off;
  logic [4:0]     sum;

  assign cand      = req & ~mask;
  assign start_eff = (mode == MODE_FP) ? '0 : start_idx;

  // rot[gi] is the candidate gi places after the start index, wrapping at N
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [IDW:0]   s;
    logic [IDW-1:0] pos;
    assign s       = {1'b0, start_eff} + (IDW + 1)'(gi);
    assign pos     = IDW'((s >= N_W) ? s - N_W : s);
    assign rot[gi] = cand[pos];
  end

  assign rot_oh   = rot & (~rot + N'(1));
  assign found    = |rot;
  assign rot_wide = 16'(rot_oh);
  assign off      = onehot2idx(rot_wide);
  assign sum      = 5'(start_eff) + {1'b0, off};
  assign idx      = IDW'((sum >= 5'(N)) ? sum - 5'(N) : sum);

endmodule

// File: rtl/arb_rr_n.sv
// N-way arbiter with grant hold, hold-time limit forcing rotation, and run-time
// round-robin / fixed-priority selection. Drives the registered one-hot grant and index.
module arb_rr_n
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  arb_rr_n_if.slave  bus
);

  localparam int IDW = $clog2(N);
  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;

  arb_state_t     state_reg;
  logic [N-1:0]   ack_reg;
  logic           gv_reg;
  logic [IDW-1:0] gid_reg;
  logic [IDW-1:0] ptr_reg;
  logic [HCW-1:0] hold_cnt_reg;

  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] ptr_next;
  logic [N-1:0]   ack_next;
  logic           holder_req;
  logic           others_req;
  logic           timeout;
  logic           hold_keep;
  logic           do_grant;

  // ack_reg doubles as the holder mask; it is all-zero in IDLE
  arb_pick #(.N(N)) u_pick (
    .req       (bus.req),
    .mask      (ack_reg),
    .start_idx (ptr_reg),
    .mode      (bus.mode),
    .found     (pick_found),
    .idx       (pick_idx)
  );

  assign holder_req = |(bus.req & ack_reg);
  assign others_req = |(bus.req & ~ack_reg);
  assign timeout    = (MAX_HOLD > 0) && (hold_cnt_reg == HOLD_LAST) && others_req;
  assign hold_keep  = (state_reg == BUSY) && holder_req && !timeout;
  assign do_grant   = pick_found && !hold_keep;
  assign ptr_next   = (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + IDW'(1);

  for (genvar gi = 0; gi < N; gi++) begin : g_dec
    assign ack_next[gi] = (pick_idx == IDW'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      ack_reg      <= '0;
      gv_reg       <= 1'b0;
      gid_reg      <= '0;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
    end else if (hold_keep) begin
      if ((MAX_HOLD > 0) && (hold_cnt_reg != HOLD_LAST)) begin
        hold_cnt_reg <= hold_cnt_reg + HCW'(1);
      end
    end else if (do_grant) begin
      state_reg    <= BUSY;
      ack_reg      <= ack_next;
      gv_reg       <= 1'b1;
      gid_reg      <= pick_idx;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= '0;
    end else if (state_reg == BUSY) begin
      // holder released and nobody else is waiting; grant_id keeps the last owner
      state_reg    <= IDLE;
      ack_reg      <= '0;
      gv_reg       <= 1'b0;
      hold_cnt_reg <= '0;
    end
  end

  assign bus.ack         = ack_reg;
  assign bus.grant_valid = gv_reg;
  assign bus.grant_id    = gid_reg;

endmodule

// File: tb/tb_arb_rr_n.sv
// Scoreboard bench: a 4-way (hold limit 4) and an 8-way (unlimited hold) arbiter,
// directed scenarios plus random request patterns, checked against an owner-based model.
module tb_arb_rr_n;
  import arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4 = 1'b1;
  logic rst8 = 1'b1;

  arb_rr_n_if #(.N(4)) bus4 ();
  arb_rr_n_if #(.N(8)) bus8 ();

  arb_rr_n #(.N(4), .MAX_HOLD(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4.slave));
  arb_rr_n #(.N(8), .MAX_HOLD(0)) dut8 (.clk(clk), .rst(rst8), .bus(bus8.slave));

  typedef struct packed {
    logic [7:0] ack;
    logic       gv;
    logic [2:0] gid;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   txn    = 0;

  // Model state per arbiter: current owner (-1 = none), last granted index,
  // cycles the owner has held the grant, last reported grant index.
  int owner[2];
  int last[2];
  int held[2];
  int gidm[2];
  int nn[2];
  int mh[2];

  function automatic int pick(input int n, input logic [7:0] rq, input int excl,
                              input bit md, input int lst);
    if (md == MODE_FP) begin
      for (int i = 0; i < n; i++) if (rq[i] && i != excl) return i;
    end else begin
      for (int k = 1; k <= n; k++) begin
        int i;
        i = (lst + k) % n;
        if (rq[i] && i != excl) return i;
      end
    end
    return -1;
  endfunction

  task automatic model_edge(input int d, input bit r, input logic [7:0] rq, input bit md);
    bit keep;
    bit others;
    int w;
    if (r) begin
      owner[d] = -1; last[d] = nn[d] - 1; held[d] = 0; gidm[d] = 0;
    end else begin
      keep = 1'b0;
      if (owner[d] >= 0 && rq[owner[d]]) begin
        others = 1'b0;
        for (int i = 0; i < nn[d]; i++) if (rq[i] && i != owner[d]) others = 1'b1;
        keep = !(mh[d] > 0 && held[d] >= mh[d] && others);
      end
      if (keep) begin
        held[d]++;
      end else begin
        w = pick(nn[d], rq, owner[d], md, last[d]);
        if (w >= 0) begin
          owner[d] = w; last[d] = w; gidm[d] = w; held[d] = 1;
        end else begin
          owner[d] = -1; held[d] = 0;
        end
      end
    end
  endtask

  function automatic obs_t model_obs(input int d);
    obs_t o;
    o.ack = (owner[d] >= 0) ? (8'd1 << owner[d]) : 8'd0;
    o.gv  = (owner[d] >= 0);
    o.gid = 3'(gidm[d]);
    return o;
  endfunction

  // Drive one arbiter for the coming edge; the other one is held in reset.
  task automatic step(input int d, input bit r, input logic [7:0] rq, input bit md);
    exp_t e;
    @(negedge clk);
    if (d == 0) begin
      rst4 = r; bus4.req = rq[3:0]; bus4.mode = md;
      rst8 = 1'b1; bus8.req = '0; bus8.mode = MODE_RR;
      model_edge(0, r, {4'b0, rq[3:0]}, md);
      model_edge(1, 1'b1, 8'h00, MODE_RR);
    end else begin
      rst8 = r; bus8.req = rq; bus8.mode = md;
      rst4 = 1'b1; bus4.req = '0; bus4.mode = MODE_RR;
      model_edge(1, r, rq, md);
      model_edge(0, 1'b1, 8'h00, MODE_RR);
    end
    e.a = model_obs(0);
    e.b = model_obs(1);
    exp_q.push_back(e);
  endtask

  task automatic steps(input int cnt, input int d, input logic [7:0] rq, input bit md);
    for (int i = 0; i < cnt; i++) step(d, 1'b0, rq, md);
  endtask

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act.ack !== exp.ack) begin
      errors++;
      $display("FAIL %s ack txn %0d: got %b want %b", name, txn, act.ack, exp.ack);
    end
    checks++;
    if (act.gv !== exp.gv) begin
      errors++;
      $display("FAIL %s grant_valid txn %0d: got %b want %b", name, txn, act.gv, exp.gv);
    end
    checks++;
    if (act.gid !== exp.gid) begin
      errors++;
      $display("FAIL %s grant_id txn %0d: got %0d want %0d", name, txn, act.gid, exp.gid);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      obs_t a4;
      obs_t a8;
      e  = exp_q.pop_front();
      a4 = {4'b0, bus4.ack, bus4.grant_valid, 1'b0, bus4.grant_id};
      a8 = {bus8.ack, bus8.grant_valid, bus8.grant_id};
      txn++;
      check_obs("dut4", a4, e.a);
      check_obs("dut8", a8, e.b);
      $display("txn %0d: ack4=%b id4=%0d ack8=%b id8=%0d", txn, bus4.ack, bus4.grant_id,
               bus8.ack, bus8.grant_id);
    end
  end

  initial begin
    logic [7:0] cur;
    bit md;
    nn[0] = 4; mh[0] = 4;
    nn[1] = 8; mh[1] = 0;
    for (int d = 0; d < 2; d++) begin
      owner[d] = -1; last[d] = nn[d] - 1; held[d] = 0; gidm[d] = 0;
    end
    bus4.req = '0; bus4.mode = MODE_RR;
    bus8.req = '0; bus8.mode = MODE_RR;

    // 4-way: round-robin walk by successive release
    step(0, 1'b1, 8'h00, MODE_RR);
    step(0, 1'b1, 8'h00, MODE_RR);
    steps(2, 0, 8'h0F, MODE_RR);
    steps(2, 0, 8'h0E, MODE_RR);
    steps(2, 0, 8'h0C, MODE_RR);
    steps(2, 0, 8'h08, MODE_RR);
    steps(2, 0, 8'h00, MODE_RR);
    // timeout alternation, then lone holder
    steps(20, 0, 8'h03, MODE_RR);
    steps(1, 0, 8'h00, MODE_RR);
    steps(20, 0, 8'h04, MODE_RR);
    steps(1, 0, 8'h00, MODE_RR);
    // fixed priority
    steps(2, 0, 8'h0C, MODE_FP);
    steps(8, 0, 8'h0D, MODE_FP);
    steps(1, 0, 8'h00, MODE_RR);
    // mid-grant reset
    steps(2, 0, 8'h08, MODE_RR);
    step(0, 1'b1, 8'h08, MODE_RR);
    steps(3, 0, 8'h0F, MODE_RR);
    // random traffic
    cur = 8'h00; md = 1'b0;
    for (int c = 0; c < 300; c++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(3) == 0) cur[b] = ~cur[b];
      if ($urandom_range(15) == 0) md = ~md;
      step(0, ($urandom_range(63) == 0), cur & 8'h0F, md);
    end

    // 8-way with unlimited hold
    step(1, 1'b1, 8'h00, MODE_RR);
    steps(50, 1, 8'hFF, MODE_RR);
    steps(3, 1, 8'hFE, MODE_RR);
    for (int c = 0; c < 200; c++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(3) == 0) cur[b] = ~cur[b];
      if ($urandom_range(15) == 0) md = ~md;
      step(1, ($urandom_range(63) == 0), cur, md);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
